// File: rtl/req_encoder_8_3.sv
// req_encoder_8_3: sticky 8-bit request bitmap emitted one 3-bit index per valid/ready transfer.
// Define RR_ARB_EN for round-robin selection; otherwise fixed priority, index 7 highest.
module req_encoder_8_3 (
    input  logic       clk,
    input  logic       rst,
    input  logic       E,
    input  logic [7:0] In,
    output logic [2:0] Out,
    output logic       V,
    input  logic       R,
    output logic [7:0] Pend,
    output logic       Ovf
);
    typedef enum logic {IDLE, VALID} state_t;
    state_t     state, state_n;
    logic       xfer;
    logic [7:0] clr, set, masked;
    logic [2:0] sel, out_n;
    assign V      = (state == VALID);
    assign xfer   = V && R;
    assign clr    = xfer ? 8'h01 << Out : 8'h00;
    assign set    = E ? In : 8'h00;
    // Candidates exclude the bit leaving on this edge; fresh captures wait a cycle.
    assign masked = Pend & ~clr;
`ifdef RR_ARB_EN
    logic [2:0] ptr, start;
    assign start = xfer ? Out - 3'd1 : ptr;
    // Nearest set bit at or below start, wrapping 0 -> 7.
    always_comb begin
        sel = '0;
        for (int i = 7; i >= 0; i--)
            if (masked[start - 3'(i)]) sel = start - 3'(i);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) ptr <= 3'd7;
        else if (xfer) ptr <= Out - 3'd1;
`else
    always_comb begin
        sel = '0;
        for (int i = 0; i < 8; i++)
            if (masked[i]) sel = 3'(i);
    end
`endif
    always_comb begin
        state_n = state;
        out_n   = Out;
        if ((state == IDLE || R) && masked != 8'h00) begin
            state_n = VALID;
            out_n   = sel;
        end else if (state == VALID && R) begin
            state_n = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            Out   <= '0;
            Pend  <= '0;
            Ovf   <= 1'b0;
        end else begin
            state <= state_n;
            Out   <= out_n;
            Pend  <= masked | set;
            Ovf   <= Ovf | (|(set & masked));
        end
    end
endmodule

// File: doc/req_encoder_8_3.md
# req_encoder_8_3

Sequential 8-to-3 request encoder, the counterpart of the team's 3-to-8 decoder. It captures one-hot or multi-hot request lines into a sticky pending bitmap and emits one 3-bit index at a time on a registered valid/ready output. Each emitted index clears its pending bit. It sits between request sources, such as decoded select lines, and any consumer of binary indices.

## Interface
- Parameters: none. Width is fixed at 8 request lines and a 3-bit code.
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- E  in  1  capture enable; In is sampled only when E=1
- In  in  8  request lines; In[i]=1 requests index i
- Out  out  3  encoded index, registered
- V  out  1  Out valid, registered
- R  in  1  consumer ready; transfer occurs on an edge where V&&R
- Pend  out  8  pending bitmap, registered
- Ovf  out  1  sticky overflow flag, registered

## Operation
- Reset (async, immediate):
  - Out=0, V=0, Pend=0, Ovf=0.
  - State=IDLE; round-robin pointer=7.
  - A transfer in flight is abandoned: V drops as soon as rst rises.
- Capture: on every edge, Pend[i] is set when E&&In[i]. With E=0, In is ignored, but Pend keeps draining.
- Clear: on a transfer edge, Pend[Out] is cleared. If the same bit is also set on that edge, the set wins and the bit stays pending.
- Overflow: Ovf is set when E&&In[i]&&Pend[i] and bit i is not being cleared on that edge. Ovf holds until rst.
- Selection: computed from the registered Pend, with the bit being transferred on that edge masked out. Bits captured on the same edge are not eligible until the next edge.
- State machine:
  - IDLE, Pend!=0: load Out=sel, V=1, go to VALID.
  - IDLE, Pend==0: stay in IDLE.
  - VALID, R=0: hold Out and V. No preemption: a higher-priority arrival does not change Out.
  - VALID, R=1, a masked candidate exists: load the next Out, stay in VALID (back-to-back).
  - VALID, R=1, no masked candidate: V=0, go to IDLE.
- Priority without the macro: fixed; the highest index wins (7 highest, 0 lowest).

## Timing
- Request to valid: In sampled at edge n, Pend visible after edge n, V=1 and Out valid after edge n+1.
- Throughput: one index per cycle while R=1 and candidates remain.
- Repeat request: a bit re-requested on its own transfer edge, with no other bit pending, gives one IDLE cycle (V=0). It is re-issued one cycle later.
- Out, V, Pend and Ovf all change only on clk edges, except on async reset.
- Out is don't-care-stable while V=0: it holds its last value, which is 0 after reset.

## Configuration
- RR_ARB_EN defined: round-robin selection.
  - After a transfer of index k, the pointer becomes k-1 mod 8.
  - The next search runs downward from the pointer, wrapping 0→7.
  - Selection while IDLE also uses the pointer.
- RR_ARB_EN undefined:
  - Fixed priority as in Operation.
  - No pointer register is synthesized.

## Test plan
- Async reset: assert rst mid-transfer with V=1, Out=5, Pend=8'h24 → V=0, Out=0, Pend=0, Ovf=0 immediately, before the next edge.
- Single request: E=1, In=8'h20 for one cycle, R=1 → Pend=8'h20 after edge n; V=1, Out=5 after edge n+1; V=0, Pend=0 after edge n+2.
- Multi request: In=8'h81 for one cycle, R=1 → consecutive valid cycles with Out=7 then Out=0, then V=0. Same result in both configurations.
- Backpressure: R=0, Pend=8'h04, V=1, Out=2; then In=8'h80 arrives.
  - Out stays 2 while R=0.
  - When R=1: Out=2 transfers, then Out=7, then V=0.
- Overflow: R=0, Pend[3]=1, In=8'h08 again → Ovf=1 and stays 1. Index 3 is issued exactly once after R=1.
- Fairness: In=8'hC1 held with E=1 and R=1.
  - Without RR_ARB_EN → Out sequence 7,6,7,6… (0 starves).
  - With RR_ARB_EN → Out sequence 7,6,0,7,6,0….
